// File: rtl/seq_div_core.sv
// Memory-mapped radix-2 restoring divider for the slot bus, signed or unsigned, one quotient bit per clock.
// Operands are snapshotted at start so software may rewrite them while a division is in flight.
module seq_div_core #(
   parameter int W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   localparam logic [2:0] A_DIVIDEND = 3'd0;
   localparam logic [2:0] A_DIVISOR  = 3'd1;
   localparam logic [2:0] A_CTRL     = 3'd2;
   localparam logic [2:0] A_STATUS   = 3'd3;
   localparam logic [2:0] A_QUOT     = 3'd4;
   localparam logic [2:0] A_REM      = 3'd5;

   logic [W-1:0] dividend_r, divisor_r, quot_r, rem_r;
   logic [W-1:0] acc_r, q_r, dsr_mag_r, dvd_snap_r;
   logic         busy_r, done_r, dbz_r, mode_r, neg_q_r, neg_r_r;
   logic [1:0]   state_r;
   logic [5:0]   cnt_r;

   logic         wr_en_s, start_s, dvd_neg_s, dsr_neg_s;
   logic [W-1:0] dvd_mag_s, dsr_mag_s, acc_nxt_s, q_nxt_s, quot_fix_s, rem_fix_s;
   logic [W:0]   shift_s, diff_s;
   logic         unused_s;

   assign unused_s = ^{read, addr[4:3], wr_data};

   function automatic logic [31:0] ext_w(input logic [W-1:0] v, input logic sgn);
      if (sgn) begin
         ext_w = 32'($signed(v));
      end else begin
         ext_w = 32'(v);
      end
   endfunction

   // Start decode, operand magnitudes, one restoring step and the final sign fixup.
   always_comb begin
      wr_en_s   = cs & write;
      start_s   = wr_en_s & (addr[2:0] == A_CTRL) & wr_data[0] & (state_r == ST_IDLE);
      dvd_neg_s = wr_data[1] & dividend_r[W-1];
      dsr_neg_s = wr_data[1] & divisor_r[W-1];
      dvd_mag_s = dvd_neg_s ? -dividend_r : dividend_r;
      dsr_mag_s = dsr_neg_s ? -divisor_r : divisor_r;
      shift_s   = {acc_r, q_r[W-1]};
      diff_s    = shift_s - {1'b0, dsr_mag_r};
      if (diff_s[W] == 1'b0) begin
         acc_nxt_s = diff_s[W-1:0];
         q_nxt_s   = {q_r[W-2:0], 1'b1};
      end else begin
         acc_nxt_s = shift_s[W-1:0];
         q_nxt_s   = {q_r[W-2:0], 1'b0};
      end
      // Divide by zero reports the raw dividend and bypasses the sign fixup.
      if (dbz_r) begin
         quot_fix_s = {W{1'b1}};
         rem_fix_s  = dvd_snap_r;
      end else begin
         quot_fix_s = neg_q_r ? -q_r : q_r;
         rem_fix_s  = neg_r_r ? -acc_r : acc_r;
      end
   end

   // Software-visible operand registers, writable at any time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dividend_r <= {W{1'b0}};
         divisor_r  <= {W{1'b0}};
      end else if (wr_en_s) begin
         case (addr[2:0])
            A_DIVIDEND: dividend_r <= wr_data[W-1:0];
            A_DIVISOR:  divisor_r  <= wr_data[W-1:0];
            default: begin
            end
         endcase
      end
   end

   // Division sequencer: IDLE -> RUN (W steps) -> FIX -> IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         dbz_r      <= 1'b0;
         mode_r     <= 1'b0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         cnt_r      <= 6'd0;
         acc_r      <= {W{1'b0}};
         q_r        <= {W{1'b0}};
         dsr_mag_r  <= {W{1'b0}};
         dvd_snap_r <= {W{1'b0}};
         quot_r     <= {W{1'b0}};
         rem_r      <= {W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  mode_r     <= wr_data[1];
                  dvd_snap_r <= dividend_r;
                  dbz_r      <= (divisor_r == {W{1'b0}});
                  busy_r     <= 1'b1;
                  done_r     <= 1'b0;
                  acc_r      <= {W{1'b0}};
                  q_r        <= dvd_mag_s;
                  dsr_mag_r  <= dsr_mag_s;
                  neg_q_r    <= dvd_neg_s ^ dsr_neg_s;
                  neg_r_r    <= dvd_neg_s;
                  cnt_r      <= 6'(W - 1);
                  state_r    <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               acc_r <= acc_nxt_s;
               q_r   <= q_nxt_s;
               if (cnt_r == 6'd0) begin
                  state_r <= ST_FIX;
               end else begin
                  cnt_r <= cnt_r - 6'd1;
               end
            end
            ST_FIX: begin
               quot_r  <= quot_fix_s;
               rem_r   <= rem_fix_s;
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Read mux; result and operand registers are extended according to the latched mode.
   always_comb begin
      case (addr[2:0])
         A_DIVIDEND: rd_data = ext_w(dividend_r, mode_r);
         A_DIVISOR:  rd_data = ext_w(divisor_r, mode_r);
         A_STATUS:   rd_data = {29'd0, dbz_r, done_r, busy_r};
         A_QUOT:     rd_data = ext_w(quot_r, mode_r);
         A_REM:      rd_data = ext_w(rem_r, mode_r);
         default:    rd_data = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_seq_div_core.sv
// Self-checking bench for seq_div_core: a W=32 and a W=8 instance, table vectors plus latency,
// ignored-start and mid-operation reset sequences, with a scoreboard queue of expected results.
module tb_seq_div_core;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [31:0] q;
      logic [31:0] r;
      logic [31:0] st;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs32 = 1'b0, cs8 = 1'b0;
   logic        read = 1'b0, write = 1'b0;
   logic [4:0]  addr = 5'd0;
   logic [31:0] wr_data = 32'd0;
   logic [31:0] rd32, rd8;

   int   passed = 0;
   int   total = 0;
   vec_t vecs[8];
   vec_t sbq[$];

   seq_div_core #(.W(32)) dut32 (
      .clk(clk), .reset(reset), .cs(cs32), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd32)
   );

   seq_div_core #(.W(8)) dut8 (
      .clk(clk), .reset(reset), .cs(cs8), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic wr(input logic is8, input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      cs32 = !is8; cs8 = is8; write = 1'b1; addr = {2'b00, a}; wr_data = d;
      @(negedge clk);
      cs32 = 1'b0; cs8 = 1'b0; write = 1'b0;
   endtask

   task automatic rd(input logic is8, input logic [2:0] a, output logic [31:0] d);
      read = 1'b1; addr = {2'b00, a};
      #1;
      d = is8 ? rd8 : rd32;
      read = 1'b0;
   endtask

   task automatic start_op(input logic is8, input logic [31:0] a, input logic [31:0] b, input logic sgn);
      wr(is8, 3'd0, a);
      wr(is8, 3'd1, b);
      wr(is8, 3'd2, {30'd0, sgn, 1'b1});
   endtask

   task automatic wait_done(input logic is8, input string nm);
      logic [31:0] s;
      int cyc;
      s = 32'd0;
      cyc = 0;
      while (cyc < 100 && s[1] == 1'b0) begin
         @(negedge clk);
         cyc++;
         rd(is8, 3'd3, s);
      end
      if (s[1] == 1'b0) begin
         chk({nm, " done timeout"}, s, 32'h2);
      end
   endtask

   task automatic check_result(input logic is8, input string nm);
      vec_t e;
      logic [31:0] d;
      if (sbq.size() == 0) begin
         chk({nm, " scoreboard empty"}, 32'(sbq.size()), 32'd1);
      end else begin
         e = sbq.pop_front();
         rd(is8, 3'd4, d); chk({nm, " quot"}, d, e.q);
         rd(is8, 3'd5, d); chk({nm, " rem"}, d, e.r);
         rd(is8, 3'd3, d); chk({nm, " status"}, d, e.st);
      end
   endtask

   initial begin
      logic [31:0] d;
      int bc;
      vecs[0] = '{32'hFFFF_FF9C, 32'd7,          1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'h2};
      vecs[1] = '{32'd100,       32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2, 32'd2,         32'h2};
      vecs[2] = '{32'h0000_1234, 32'd0,          1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 32'h6};
      vecs[3] = '{32'hFFFF_FFFB, 32'd0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h6};
      vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0,         32'h2};
      vecs[5] = '{32'hFFFF_FFFF, 32'd2,          1'b0, 32'h7FFF_FFFF, 32'd1,         32'h2};
      vecs[6] = '{32'd7,         32'd9,          1'b0, 32'd0,         32'd7,         32'h2};
      vecs[7] = '{32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h2};

      repeat (2) @(negedge clk);
      rd(1'b0, 3'd3, d); chk("reset status", d, 32'd0);
      rd(1'b0, 3'd4, d); chk("reset quot", d, 32'd0);
      rd(1'b0, 3'd5, d); chk("reset rem", d, 32'd0);
      rd(1'b0, 3'd0, d); chk("reset dividend", d, 32'd0);
      rd(1'b1, 3'd3, d); chk("reset status w8", d, 32'd0);
      reset = 1'b0;

      // Unsigned 100/7 with the exact busy/done timeline.
      start_op(1'b0, 32'd100, 32'd7, 1'b0);
      sbq.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32'h2});
      bc = 0;
      for (int c = 1; c <= 33; c++) begin
         rd(1'b0, 3'd3, d);
         if (d == 32'h1) bc++;
         if (c < 33) @(negedge clk);
      end
      chk("busy cycles 1..33", 32'(bc), 32'd33);
      @(negedge clk);
      rd(1'b0, 3'd3, d); chk("done at cycle 34", d, 32'h2);
      check_result(1'b0, "u100/7");

      for (int i = 0; i < 8; i++) begin
         start_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].sgn);
         sbq.push_back(vecs[i]);
         wait_done(1'b0, $sformatf("vec%0d", i));
         check_result(1'b0, $sformatf("vec%0d", i));
      end

      // A second start during RUN must be ignored; operand registers still update.
      start_op(1'b0, 32'd1000, 32'd10, 1'b0);
      sbq.push_back('{32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 32'h2});
      repeat (4) @(negedge clk);
      start_op(1'b0, 32'd50, 32'd5, 1'b1);
      rd(1'b0, 3'd3, d); chk("busy after ignored start", d, 32'h1);
      wait_done(1'b0, "ignored");
      check_result(1'b0, "ignored");
      rd(1'b0, 3'd0, d); chk("dividend rewritten", d, 32'd50);

      // W=8 signed 0x81/0x03 with sign-extended readback.
      start_op(1'b1, 32'h81, 32'h03, 1'b1);
      sbq.push_back('{32'h81, 32'h03, 1'b1, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 32'h2});
      repeat (8) @(negedge clk);
      rd(1'b1, 3'd3, d); chk("w8 busy at cycle 9", d, 32'h1);
      @(negedge clk);
      rd(1'b1, 3'd3, d); chk("w8 done at cycle 10", d, 32'h2);
      check_result(1'b1, "w8 s81/3");
      rd(1'b1, 3'd0, d); chk("w8 dividend sext", d, 32'hFFFF_FF81);

      // Reset at cycle 5 of a division, then a clean 9/3.
      start_op(1'b0, 32'd1000, 32'd7, 1'b0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      rd(1'b0, 3'd3, d); chk("midreset status", d, 32'd0);
      rd(1'b0, 3'd4, d); chk("midreset quot", d, 32'd0);
      rd(1'b0, 3'd5, d); chk("midreset rem", d, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      start_op(1'b0, 32'd9, 32'd3, 1'b0);
      sbq.push_back('{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 32'h2});
      wait_done(1'b0, "post-reset");
      check_result(1'b0, "post-reset 9/3");
      chk("scoreboard drained", 32'(sbq.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
